// File: rtl/cu_read_data_assembler_if.sv
// cu_read_data_assembler_if
// Purpose: bundles the half-beat capture inputs and the full-line output
//          handshake of the read data assembler.
// Signals:
//   h0_valid/h0_slot/h0_data/h0_real_size : lower-half beat, its slot and element count
//   h1_valid/h1_slot/h1_data              : upper-half beat and its slot
//   out_valid/out_ready                   : full-line handshake
//   out_data/out_slot/out_real_size       : assembled line (lower half at MSB end)
// Modports: master = upstream/downstream side, slave = assembler side.
interface cu_read_data_assembler_if #(
   parameter int unsigned DATA_W = 512,
   parameter int unsigned SLOTS  = 4
);
   localparam int unsigned SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   logic                  h0_valid;
   logic [SW-1:0]         h0_slot;
   logic [DATA_W-1:0]     h0_data;
   logic [7:0]            h0_real_size;
   logic                  h1_valid;
   logic [SW-1:0]         h1_slot;
   logic [DATA_W-1:0]     h1_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*DATA_W-1:0]   out_data;
   logic [SW-1:0]         out_slot;
   logic [7:0]            out_real_size;

   modport master (
      output h0_valid, h0_slot, h0_data, h0_real_size,
      output h1_valid, h1_slot, h1_data,
      output out_ready,
      input  out_valid, out_data, out_slot, out_real_size
   );

   modport slave (
      input  h0_valid, h0_slot, h0_data, h0_real_size,
      input  h1_valid, h1_slot, h1_data,
      input  out_ready,
      output out_valid, out_data, out_slot, out_real_size
   );
endinterface

// File: rtl/cu_read_data_assembler.sv
// cu_read_data_assembler
// Purpose: pairs lower/upper half-cacheline beats per pending slot into full
//          lines and queues completed lines in a show-ahead output FIFO.
// Ports:
//   clock, rstn   : clock and asynchronous active-low reset
//   enable_in     : global advance enable; low freezes all state
//   bus (slave)   : half-beat inputs and full-line output handshake
//   fifo_alfull   : registered almost-full throttle for upstream read issue
//   lines_done    : running sum of real_size over popped lines (wraps)
//   err_dup       : sticky flag, a half arrived for an already-filled half slot
module cu_read_data_assembler #(
   parameter int unsigned DATA_W        = 512,
   parameter int unsigned SLOTS         = 4,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned ALFULL_MARGIN = 4
) (
   input  logic                          clock,
   input  logic                          rstn,
   input  logic                          enable_in,
   cu_read_data_assembler_if.slave       bus,
   output logic                          fifo_alfull,
   output logic [31:0]                   lines_done,
   output logic                          err_dup
);

   localparam int unsigned SW         = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW         = $clog2(DEPTH) + 1;
   localparam int unsigned LW         = 2 * DATA_W;
   localparam int unsigned EW         = LW + SW + 8;
   localparam int unsigned ALFULL_LVL = (DEPTH > ALFULL_MARGIN) ? (DEPTH - ALFULL_MARGIN) : 0;

   // Pending-line slot state
   logic [SLOTS-1:0]   has0_q, has0_d;
   logic [SLOTS-1:0]   has1_q, has1_d;
   logic [DATA_W-1:0]  data0_q [SLOTS];
   logic [DATA_W-1:0]  data1_q [SLOTS];
   logic [7:0]         size_q  [SLOTS];

   // Output FIFO state; head_q is a registered copy of the entry at rd_ptr
   logic [EW-1:0]      mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [EW-1:0]      head_q, head_d;
   logic               out_valid_q;
   logic               alfull_q;
   logic [31:0]        lines_q, lines_d;
   logic               err_q;

   logic [SLOTS-1:0]   complete_c;
   logic               xfer_any_c;
   logic [SW-1:0]      xfer_slot_c;
   logic               full_c;
   logic               pop_c;
   logic               push_c;
   logic               cap0_c;
   logic               cap1_c;
   logic               dup_c;
   logic [EW-1:0]      push_entry_c;

   // Lowest-index complete slot is the transfer candidate
   always_comb begin
      complete_c  = has0_q & has1_q;
      xfer_any_c  = 1'b0;
      xfer_slot_c = '0;
      for (int i = 0; i < int'(SLOTS); i++) begin
         if (complete_c[i] && !xfer_any_c) begin
            xfer_any_c  = 1'b1;
            xfer_slot_c = SW'(i);
         end
      end
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle
   always_comb begin
      full_c       = (count_q == CW'(DEPTH));
      pop_c        = enable_in & out_valid_q & bus.out_ready;
      push_c       = enable_in & xfer_any_c & (~full_c | pop_c);
      push_entry_c = {data0_q[xfer_slot_c], data1_q[xfer_slot_c], xfer_slot_c, size_q[xfer_slot_c]};
   end

   // Has-bit update: the transfer clear is applied first so a half arriving
   // for the slot being transferred is accepted instead of flagged duplicate
   always_comb begin
      has0_d = has0_q;
      has1_d = has1_q;
      cap0_c = 1'b0;
      cap1_c = 1'b0;
      dup_c  = 1'b0;
      if (push_c) begin
         has0_d[xfer_slot_c] = 1'b0;
         has1_d[xfer_slot_c] = 1'b0;
      end
      if (enable_in && bus.h0_valid) begin
         if (has0_d[bus.h0_slot]) begin
            dup_c = 1'b1;
         end else begin
            cap0_c                = 1'b1;
            has0_d[bus.h0_slot]   = 1'b1;
         end
      end
      if (enable_in && bus.h1_valid) begin
         if (has1_d[bus.h1_slot]) begin
            dup_c = 1'b1;
         end else begin
            cap1_c                = 1'b1;
            has1_d[bus.h1_slot]   = 1'b1;
         end
      end
   end

   // FIFO pointer, occupancy, head and statistics next state
   always_comb begin
      wr_ptr_d = push_c ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_c  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      count_d  = count_q;
      if (push_c && !pop_c) begin
         count_d = count_q + CW'(1);
      end else if (pop_c && !push_c) begin
         count_d = count_q - CW'(1);
      end
      // The new head is the entry being written this edge when it lands at rd_ptr_d
      head_d = '0;
      if (count_d != '0) begin
         if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_entry_c;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
      lines_d = lines_q;
      if (pop_c) begin
         lines_d = lines_q + 32'(head_q[7:0]);
      end
   end

   // Control and output registers
   always_ff @(posedge clock or negedge rstn) begin
      if (!rstn) begin
         has0_q      <= '0;
         has1_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         head_q      <= '0;
         out_valid_q <= 1'b0;
         alfull_q    <= 1'b0;
         lines_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         has0_q      <= has0_d;
         has1_q      <= has1_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         head_q      <= head_d;
         out_valid_q <= (count_d != '0);
         alfull_q    <= (count_d >= CW'(ALFULL_LVL));
         lines_q     <= lines_d;
         err_q       <= err_q | dup_c;
      end
   end

   // Data storage; validity is tracked by the has-bits and FIFO occupancy
   always_ff @(posedge clock) begin
      if (cap0_c) begin
         data0_q[bus.h0_slot] <= bus.h0_data;
         size_q[bus.h0_slot]  <= bus.h0_real_size;
      end
      if (cap1_c) begin
         data1_q[bus.h1_slot] <= bus.h1_data;
      end
      if (push_c) begin
         mem_q[wr_ptr_q] <= push_entry_c;
      end
   end

   assign bus.out_valid     = out_valid_q;
   assign bus.out_data      = head_q[8+SW +: LW];
   assign bus.out_slot      = head_q[8 +: SW];
   assign bus.out_real_size = head_q[7:0];
   assign fifo_alfull       = alfull_q;
   assign lines_done        = lines_q;
   assign err_dup           = err_q;

endmodule

// File: tb/tb_cu_read_data_assembler.sv
// tb_cu_read_data_assembler
// Purpose: self-checking bench for cu_read_data_assembler: directed vector
// table, multi-cycle corner sequences and randomized traffic against a
// queue-based reference model.
module tb_cu_read_data_assembler;

   localparam int DW = 64;
   localparam int SL = 4;
   localparam int DP = 16;
   localparam int AM = 4;

   localparam logic [63:0] VA = 64'hA0A0_0000_0000_000A;
   localparam logic [63:0] VB = 64'hB0B0_0000_0000_000B;
   localparam logic [63:0] VC = 64'hC0C0_0000_0000_000C;
   localparam logic [63:0] VD = 64'hD0D0_0000_0000_000D;
   localparam logic [63:0] VE = 64'hE0E0_0000_0000_000E;
   localparam logic [63:0] VF = 64'hF0F0_0000_0000_000F;
   localparam logic [63:0] VG = 64'h1111_0000_0000_0001;
   localparam logic [63:0] VH = 64'h2222_0000_0000_0002;
   localparam logic [63:0] VI = 64'h3333_0000_0000_0003;
   localparam logic [63:0] VJ = 64'h4444_0000_0000_0004;
   localparam logic [63:0] VK = 64'h5555_0000_0000_0005;
   localparam logic [63:0] VL = 64'h6666_0000_0000_0006;
   localparam logic [63:0] VM = 64'h7777_0000_0000_0007;

   logic        clock;
   logic        rstn;
   logic        enable_in;
   logic        fifo_alfull;
   logic [31:0] lines_done;
   logic        err_dup;

   cu_read_data_assembler_if #(.DATA_W(DW), .SLOTS(SL)) bus ();

   cu_read_data_assembler #(
      .DATA_W(DW), .SLOTS(SL), .DEPTH(DP), .ALFULL_MARGIN(AM)
   ) dut (
      .clock       (clock),
      .rstn        (rstn),
      .enable_in   (enable_in),
      .bus         (bus),
      .fifo_alfull (fifo_alfull),
      .lines_done  (lines_done),
      .err_dup     (err_dup)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [127:0] data;
      int unsigned  slot;
      int unsigned  size;
   } line_t;

   line_t        mq[$];
   bit           m_has0 [SL];
   bit           m_has1 [SL];
   logic [63:0]  m_d0 [SL];
   logic [63:0]  m_d1 [SL];
   int unsigned  m_sz [SL];
   bit [31:0]    m_lines;
   bit           m_err;

   function automatic void model_reset();
      mq.delete();
      for (int i = 0; i < SL; i++) begin
         m_has0[i] = 1'b0;
         m_has1[i] = 1'b0;
      end
      m_lines = '0;
      m_err   = 1'b0;
   endfunction

   // One clock edge: pop head, move the lowest complete slot if there is
   // room afterwards, then capture incoming halves against the updated slots.
   function automatic void model_edge();
      int c;
      line_t ln;
      if (!enable_in) return;
      if (bus.out_ready && mq.size() > 0) begin
         m_lines = m_lines + 32'(mq[0].size);
         void'(mq.pop_front());
      end
      c = -1;
      for (int i = 0; i < SL; i++) begin
         if (c < 0 && m_has0[i] && m_has1[i]) c = i;
      end
      if (c >= 0 && mq.size() < DP) begin
         ln.data = {m_d0[c], m_d1[c]};
         ln.slot = c;
         ln.size = m_sz[c];
         mq.push_back(ln);
         m_has0[c] = 1'b0;
         m_has1[c] = 1'b0;
      end
      if (bus.h0_valid) begin
         if (m_has0[bus.h0_slot]) m_err = 1'b1;
         else begin
            m_has0[bus.h0_slot] = 1'b1;
            m_d0[bus.h0_slot]   = bus.h0_data;
            m_sz[bus.h0_slot]   = bus.h0_real_size;
         end
      end
      if (bus.h1_valid) begin
         if (m_has1[bus.h1_slot]) m_err = 1'b1;
         else begin
            m_has1[bus.h1_slot] = 1'b1;
            m_d1[bus.h1_slot]   = bus.h1_data;
         end
      end
   endfunction

   task automatic model_compare();
      chk("model_valid", bus.out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("model_data", bus.out_data, mq[0].data);
         chk("model_slot", bus.out_slot, mq[0].slot);
         chk("model_size", bus.out_real_size, mq[0].size);
      end
      chk("model_alfull", fifo_alfull, mq.size() >= DP - AM);
      chk("model_lines", lines_done, m_lines);
      chk("model_err", err_dup, m_err);
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      model_compare();
   endtask

   task automatic drive(input bit en, input bit h0v, input int h0s, input logic [63:0] h0d,
                        input int sz, input bit h1v, input int h1s, input logic [63:0] h1d,
                        input bit rdy);
      enable_in            = en;
      bus.h0_valid         = h0v;
      bus.h0_slot          = 2'(h0s);
      bus.h0_data          = h0d;
      bus.h0_real_size     = 8'(sz);
      bus.h1_valid         = h1v;
      bus.h1_slot          = 2'(h1s);
      bus.h1_data          = h1d;
      bus.out_ready        = rdy;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, bus.out_valid, 0);
      chk({tag, "_data"}, bus.out_data, 0);
      chk({tag, "_slot"}, bus.out_slot, 0);
      chk({tag, "_size"}, bus.out_real_size, 0);
      chk({tag, "_alfull"}, fifo_alfull, 0);
      chk({tag, "_lines"}, lines_done, 0);
      chk({tag, "_err"}, err_dup, 0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit           h0v;
      int           h0s;
      logic [63:0]  h0d;
      int           sz;
      bit           h1v;
      int           h1s;
      logic [63:0]  h1d;
      bit           rdy;
      bit           ev;
      logic [127:0] ed;
      int           es;
      int           esz;
      int           el;
      bit           eerr;
   } vec_t;

   localparam int NV = 23;
   vec_t tbl [NV];

   function automatic vec_t mkv(bit h0v, int h0s, logic [63:0] h0d, int sz,
                                bit h1v, int h1s, logic [63:0] h1d, bit rdy,
                                bit ev, logic [127:0] ed, int es, int esz, int el, bit eerr);
      vec_t v;
      v.h0v = h0v; v.h0s = h0s; v.h0d = h0d; v.sz = sz;
      v.h1v = h1v; v.h1s = h1s; v.h1d = h1d; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.es = es; v.esz = esz; v.el = el; v.eerr = eerr;
      return v;
   endfunction

   initial begin
      int unsigned exp_sum;
      logic [63:0] r0, r1;

      // two-edge assembly from halves at edges 0 and 3; pop adds 16
      tbl[0]  = mkv(1,2,VA,16, 0,0,0, 1, 0,0,0,0, 0, 0);
      tbl[1]  = mkv(0,0,0,0,   0,0,0, 1, 0,0,0,0, 0, 0);
      tbl[2]  = mkv(0,0,0,0,   0,0,0, 1, 0,0,0,0, 0, 0);
      tbl[3]  = mkv(0,0,0,0,   1,2,VB,1, 0,0,0,0, 0, 0);
      tbl[4]  = mkv(0,0,0,0,   0,0,0, 1, 1,{VA,VB},2,16, 0, 0);
      tbl[5]  = mkv(0,0,0,0,   0,0,0, 1, 0,0,0,0, 16, 0);
      // slots 0 and 2 complete together: slot 0 first, slot 2 one edge later
      tbl[6]  = mkv(1,0,VC,3,  1,2,VF,0, 0,0,0,0, 16, 0);
      tbl[7]  = mkv(1,2,VE,5,  1,0,VD,0, 0,0,0,0, 16, 0);
      tbl[8]  = mkv(0,0,0,0,   0,0,0, 0, 1,{VC,VD},0,3, 16, 0);
      tbl[9]  = mkv(0,0,0,0,   0,0,0, 0, 1,{VC,VD},0,3, 16, 0);
      tbl[10] = mkv(0,0,0,0,   0,0,0, 1, 1,{VE,VF},2,5, 19, 0);
      tbl[11] = mkv(0,0,0,0,   0,0,0, 1, 0,0,0,0, 24, 0);
      // duplicate lower half is dropped and flagged
      tbl[12] = mkv(1,0,VG,7,  0,0,0, 1, 0,0,0,0, 24, 0);
      tbl[13] = mkv(1,0,VH,9,  0,0,0, 1, 0,0,0,0, 24, 1);
      tbl[14] = mkv(0,0,0,0,   1,0,VI,1, 0,0,0,0, 24, 1);
      tbl[15] = mkv(0,0,0,0,   0,0,0, 1, 1,{VG,VI},0,7, 24, 1);
      tbl[16] = mkv(0,0,0,0,   0,0,0, 1, 0,0,0,0, 31, 1);
      // upper half first on slot 1, then slot 3 with both halves at once
      tbl[17] = mkv(0,0,0,0,   1,1,VJ,0, 0,0,0,0, 31, 1);
      tbl[18] = mkv(1,1,VK,1,  0,0,0, 0, 0,0,0,0, 31, 1);
      tbl[19] = mkv(1,3,VL,2,  1,3,VM,0, 1,{VK,VJ},1,1, 31, 1);
      tbl[20] = mkv(0,0,0,0,   0,0,0, 0, 1,{VK,VJ},1,1, 31, 1);
      tbl[21] = mkv(0,0,0,0,   0,0,0, 1, 1,{VL,VM},3,2, 32, 1);
      tbl[22] = mkv(0,0,0,0,   0,0,0, 1, 0,0,0,0, 34, 1);

      // reset state
      rstn = 1'b0;
      drive(0,0,0,0,0,0,0,0,0);
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      chk_all_zero("reset");
      rstn = 1'b1;

      for (int v = 0; v < NV; v++) begin
         drive(1, tbl[v].h0v, tbl[v].h0s, tbl[v].h0d, tbl[v].sz,
               tbl[v].h1v, tbl[v].h1s, tbl[v].h1d, tbl[v].rdy);
         step();
         chk($sformatf("tbl_valid[%0d]", v), bus.out_valid, tbl[v].ev);
         chk($sformatf("tbl_lines[%0d]", v), lines_done, tbl[v].el);
         chk($sformatf("tbl_err[%0d]", v), err_dup, tbl[v].eerr);
         if (tbl[v].ev) begin
            chk($sformatf("tbl_data[%0d]", v), bus.out_data, tbl[v].ed);
            chk($sformatf("tbl_slot[%0d]", v), bus.out_slot, tbl[v].es);
            chk($sformatf("tbl_size[%0d]", v), bus.out_real_size, tbl[v].esz);
         end
      end

      // fill 16 lines with the sink stalled, 17th line waits in its slot
      for (int i = 0; i < 17; i++) begin
         r0 = {$urandom, $urandom};
         r1 = {$urandom, $urandom};
         drive(1, 1, i % 4, r0, i + 1, 1, i % 4, r1, 0);
         step();
         chk($sformatf("fill_alfull[%0d]", i), fifo_alfull, (i >= 12));
      end
      drive(1,0,0,0,0,0,0,0,0);
      repeat (3) step();
      chk("full_alfull", fifo_alfull, 1);
      chk("full_head_slot", bus.out_slot, 0);
      chk("full_head_size", bus.out_real_size, 1);
      // drain: the held line enters on the first pop while full
      drive(1,0,0,0,0,0,0,0,1);
      exp_sum = 34;
      for (int k = 0; k < 17; k++) begin
         chk($sformatf("drain_valid[%0d]", k), bus.out_valid, 1);
         chk($sformatf("drain_slot[%0d]", k), bus.out_slot, k % 4);
         chk($sformatf("drain_size[%0d]", k), bus.out_real_size, k + 1);
         exp_sum += k + 1;
         step();
         if (k == 0) chk("drain_alfull_pushpop", fifo_alfull, 1);
      end
      chk("drain_empty", bus.out_valid, 0);
      chk("drain_lines", lines_done, exp_sum);

      // reset with 3 buffered lines and 2 pending halves
      drive(1, 1, 0, 64'h1, 4, 1, 0, 64'h2, 0); step();
      drive(1, 1, 1, 64'h3, 4, 1, 1, 64'h4, 0); step();
      drive(1, 1, 2, 64'h5, 4, 1, 2, 64'h6, 0); step();
      drive(1, 1, 3, 64'h7, 4, 0, 0, 0,     0); step();
      drive(1, 0, 0, 0,     0, 1, 0, 64'h8, 0); step();
      drive(1,0,0,0,0,0,0,0,0);
      step();
      chk("pre_reset_valid", bus.out_valid, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk_all_zero("midreset");
      model_reset();
      @(posedge clock);
      #1;
      chk("reset_hold_valid", bus.out_valid, 0);
      rstn = 1'b1;
      drive(1,0,0,0,0,0,0,0,1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("post_reset_idle[%0d]", i), bus.out_valid, 0);
      end
      // a lone upper half must not pair with any stale lower half
      drive(1, 0, 0, 0, 0, 1, 3, 64'h99, 0); step();
      drive(1,0,0,0,0,0,0,0,0);
      step(); step();
      chk("post_reset_no_stale", bus.out_valid, 0);
      drive(1, 1, 3, 64'h77, 9, 0, 0, 0, 0); step();
      drive(1,0,0,0,0,0,0,0,0); step();
      chk("post_reset_valid", bus.out_valid, 1);
      chk("post_reset_slot", bus.out_slot, 3);
      chk("post_reset_size", bus.out_real_size, 9);
      chk("post_reset_data", bus.out_data, {64'h77, 64'h99});

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 9) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, SL - 1), {$urandom, $urandom},
               $urandom_range(0, 255),
               $urandom_range(0, 2) == 0, $urandom_range(0, SL - 1), {$urandom, $urandom},
               $urandom_range(0, 9) < 7);
         step();
      end
      drive(1,0,0,0,0,0,0,0,1);
      repeat (40) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
